// File: rtl/serial_word_comparator.sv
// serial_word_comparator: bit-serial compare of two WIDTH-bit words (clk, rst, in_valid/in_a/in_b/msb_first/signed_mode/abort in; busy, out_valid, out_less/out_eq/out_greater out)
module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_a,
  input  logic in_b,
  input  logic msb_first,
  input  logic signed_mode,
  input  logic abort,
  output logic busy,
  output logic out_valid,
  output logic out_less,
  output logic out_eq,
  output logic out_greater
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {EQUAL, LESS, GREATER} dec_t;
  logic [CW-1:0] cnt;
  dec_t dec, cur, pair, nxt;
  logic msb_q, sgn_q, m, s, first, last, is_sign;
  assign first = cnt == '0;
  assign last = cnt == CW'(WIDTH - 1);
  assign m = first ? msb_first : msb_q;
  assign s = first ? signed_mode : sgn_q;
  assign is_sign = m ? first : last;
  assign cur = first ? EQUAL : dec;
  // a differing sign-bit pair flips polarity: a negative A is the smaller one
  assign pair = (in_a ^ (s & is_sign)) ? GREATER : LESS;
  assign nxt = (in_a == in_b) ? cur : (m ? ((cur == EQUAL) ? pair : cur) : pair);
  assign busy = !first;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dec <= EQUAL;
      msb_q <= 1'b0;
      sgn_q <= 1'b0;
      out_valid <= 1'b0;
      out_less <= 1'b0;
      out_eq <= 1'b0;
      out_greater <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (abort) begin
        cnt <= '0;
        dec <= EQUAL;
      end else if (in_valid) begin
        msb_q <= m;
        sgn_q <= s;
        dec <= nxt;
        cnt <= last ? '0 : cnt + CW'(1);
        if (last) begin
          out_valid <= 1'b1;
          out_less <= nxt == LESS;
          out_eq <= nxt == EQUAL;
          out_greater <= nxt == GREATER;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator: directed self-checking bench for serial_word_comparator
module tb_serial_word_comparator;
  logic clk = 1'b0, rst, in_valid, in_a, in_b, msb_first, signed_mode, abort;
  logic busy, out_valid, out_less, out_eq, out_greater;
  int checks = 0, errors = 0;
  logic [2:0] got[$];
  localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001;
  serial_word_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .msb_first(msb_first), .signed_mode(signed_mode), .abort(abort),
    .busy(busy), .out_valid(out_valid), .out_less(out_less), .out_eq(out_eq),
    .out_greater(out_greater)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) got.push_back({out_less, out_eq, out_greater});
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic msb, input logic sgn,
                      input logic gap, input int nbits, input logic abort_last);
    for (int i = 0; i < nbits; i++) begin
      if (gap) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          if (i > 0) chk("busy_gap", busy, 1);
          in_valid = 1'b0;
          in_a = 1'($urandom);
          in_b = 1'($urandom);
        end
      end
      @(negedge clk);
      if (gap && i > 0) chk("busy_bit", busy, 1);
      in_valid = 1'b1;
      in_a = a[msb ? 7 - i : i];
      in_b = b[msb ? 7 - i : i];
      msb_first = (i == 0) ? msb : ~msb;
      signed_mode = (i == 0) ? sgn : ~sgn;
      abort = abort_last && i == nbits - 1;
    end
  endtask
  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
    msb_first = 1'b0; signed_mode = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {busy, out_valid, out_less, out_eq, out_greater}, 0);
    send(8'h5A, 8'h5B, 1, 0, 0, 8, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_res", {out_less, out_eq, out_greater}, LT);
    @(negedge clk);
    chk("t1_pulse", out_valid, 0);
    chk("t1_hold", {out_less, out_eq, out_greater}, LT);
    repeat (2) @(negedge clk);
    got.delete();
    send(8'h80, 8'h01, 1, 1, 0, 8, 0);
    send(8'h80, 8'h01, 1, 0, 0, 8, 0);
    settle();
    chk("t2_count", got.size(), 2);
    chk("t2_signed", got.size() > 0 ? got.pop_front() : 3'bx, LT);
    chk("t2_unsigned", got.size() > 0 ? got.pop_front() : 3'bx, GT);
    send(8'h01, 8'h80, 0, 0, 1, 8, 0);
    settle();
    send(8'hC3, 8'hC3, 0, 0, 1, 8, 0);
    settle();
    chk("t3_idle", busy, 0);
    chk("t3_count", got.size(), 2);
    chk("t3_less", got.size() > 0 ? got.pop_front() : 3'bx, LT);
    chk("t3_eq", got.size() > 0 ? got.pop_front() : 3'bx, EQ);
    send(8'h7F, 8'hFF, 0, 1, 0, 8, 0);
    settle();
    chk("t4_count", got.size(), 1);
    chk("t4_gt", got.size() > 0 ? got.pop_front() : 3'bx, GT);
    send(8'h00, 8'hFF, 1, 0, 0, 4, 0);
    @(negedge clk);
    chk("t5_busy", busy, 1);
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort = 1'b0;
    chk("t5_abort_idle", busy, 0);
    chk("t5_abort_hold", {out_less, out_eq, out_greater}, GT);
    send(8'h10, 8'h0F, 1, 0, 0, 8, 0);
    settle();
    chk("t5_count", got.size(), 1);
    chk("t5_gt", got.size() > 0 ? got.pop_front() : 3'bx, GT);
    send(8'hFF, 8'h00, 1, 0, 0, 8, 1);
    settle();
    chk("t7_suppress", got.size(), 0);
    chk("t7_idle", busy, 0);
    send(8'h00, 8'h01, 1, 0, 0, 8, 0);
    settle();
    chk("t7_next", got.size() > 0 ? got.pop_front() : 3'bx, LT);
    send(8'hAA, 8'h55, 1, 0, 0, 5, 0);
    @(negedge clk);
    in_valid = 1'b1;
    rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    chk("t6_reset", {busy, out_valid, out_less, out_eq, out_greater}, 0);
    send(8'h00, 8'h00, 1, 0, 0, 8, 0);
    settle();
    chk("t6_count", got.size(), 1);
    chk("t6_eq", got.size() > 0 ? got.pop_front() : 3'bx, EQ);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
